apb_master: RTL and testbench
=============================

Name: apb_master

Overview:
- APB requester that drives the peripheral bus toward the CSR-backed APB slaves.
- Accepts one command at a time from an internal valid/ready command port.
- Runs the APB SETUP/ACCESS sequence, waits for PREADY (with timeout) and returns read data and status on a valid/ready response port.
- Sits between the host-side control logic and the APB fabric.

Parameters:
- ADDR_W, 32, width of cmd_addr and PADDR.
- TIMEOUT, 16, maximum ACCESS cycles without PREADY before abort. 0 disables the timeout.

Ports:
- PCLK  in  1  bus clock; all logic is on its rising edge.
- PRESET  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target byte address.
- cmd_wdata  in  32  write data.
- cmd_strb  in  4  write byte enables.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  32  read data (0 for writes).
- rsp_error  out  1  PSLVERR seen or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  32  APB write data.
- PSTRB  out  4  APB byte strobes.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.

Behaviour:
- Clocking: one clock, PCLK. PRESET is synchronous, active-high.
- Reset: state=IDLE. PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_valid, rsp_rdata, rsp_error, rsp_timeout are all 0. Wait counter is 0. Reset mid-transfer abandons the transfer on the next edge: PSEL=0 and no response is issued.
- All APB and rsp_* outputs are registered. cmd_ready = (state==IDLE), decoded from the state register.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - PSEL=0, PENABLE=0.
  - On cmd_valid && cmd_ready, capture the command into PWRITE/PADDR/PWDATA/PSTRB and go to SETUP.
  - PSTRB is forced to 4'h0 when cmd_write=0.
- SETUP (exactly 1 cycle): PSEL=1, PENABLE=0. Go to ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - PADDR, PWRITE, PWDATA and PSTRB are held stable from SETUP until the transfer ends.
  - Each cycle with PREADY=0 increments the counter.
  - If PREADY=1: capture rsp_rdata = PWRITE ? 0 : PRDATA, rsp_error = PSLVERR, rsp_timeout = 0. Drop PSEL/PENABLE and go to RESP.
  - Else if TIMEOUT!=0 and counter == TIMEOUT-1: rsp_rdata=0, rsp_error=1, rsp_timeout=1. Drop PSEL/PENABLE and go to RESP.
  - If PREADY arrives on the timeout cycle, PREADY wins.
  - Counter clears on entry to SETUP. Counter width is clog2(TIMEOUT+1), minimum 1.
- RESP:
  - rsp_valid=1. rsp_* are held stable until rsp_ready.
  - On rsp_ready, clear rsp_valid and go to IDLE.
  - PSEL=0 throughout; no new command is accepted.
- Latency and throughput:
  - Zero-wait transfer: command accepted at edge N, PSEL rises after N, PENABLE rises after N+1, response valid after N+2.
  - Minimum 4 cycles per command, including the return to IDLE.
- Between transfers, PADDR/PWDATA/PWRITE retain their last values. PENABLE is never 1 while PSEL is 0.
- PSLVERR and PRDATA are sampled only in the cycle where PSEL && PENABLE && PREADY.

Test Plan:
- Zero-wait write: cmd_write=1, addr=0x04, wdata=0xDEADBEEF, strb=0xF, PREADY tied 1 -> PSEL one cycle before PENABLE; one ACCESS cycle with PADDR=0x04, PWDATA=0xDEADBEEF; rsp_valid with rsp_error=0, rsp_rdata=0.
- Read with 3 wait states: addr=0x01, PREADY low for 3 ACCESS cycles then high with PRDATA=0x12345678 -> PADDR stable for all 4 ACCESS cycles; PSTRB=0; rsp_rdata=0x12345678.
- Slave error: read addr=0x100, PSLVERR=1 with PREADY -> rsp_error=1, rsp_timeout=0.
- Timeout: TIMEOUT=16, PREADY held 0 -> exactly 16 ACCESS cycles, then PSEL=0 and rsp_valid with rsp_error=1, rsp_timeout=1. Repeat with PREADY=1 on cycle 16 -> normal completion.
- Response backpressure: rsp_ready=0 for 5 cycles -> rsp_* stable, cmd_ready=0, PSEL=0 throughout; the next command is accepted only after the handshake.
- Reset mid-ACCESS: assert PRESET during a wait state -> next cycle PSEL=0, PENABLE=0, rsp_valid=0, cmd_ready=1 after release.

Source files
------------

// File: rtl/apb_master.sv
// APB requester: one command at a time from a valid/ready port, full
// SETUP/ACCESS sequencing with wait-state timeout, registered response.
module apb_master #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    input  logic [3:0]        cmd_strb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_error,
    output logic              rsp_timeout,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [31:0]       PWDATA,
    output logic [3:0]        PSTRB,
    input  logic [31:0]       PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam int CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX =
        CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    assign cmd_ready = (state == IDLE);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            PSTRB       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        PWRITE   <= cmd_write;
                        PADDR    <= cmd_addr;
                        PWDATA   <= cmd_wdata;
                        PSTRB    <= cmd_write ? cmd_strb : 4'h0;
                        PSEL     <= 1'b1;
                        wait_cnt <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        rsp_rdata   <= PWRITE ? 32'h0 : PRDATA;
                        rsp_error   <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        // PREADY takes priority over an expiring timeout
                        if (TIMEOUT != 0 && wait_cnt == CNT_MAX) begin
                            rsp_rdata   <= 32'h0;
                            rsp_error   <= 1'b1;
                            rsp_timeout <= 1'b1;
                            rsp_valid   <= 1'b1;
                            PSEL        <= 1'b0;
                            PENABLE     <= 1'b0;
                            state       <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: a scripted APB slave per transfer
// and a transaction-level model of the expected response.
module tb_apb_master;

    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 16;

    logic              PCLK = 0;
    logic              PRESET = 1;
    logic              cmd_valid = 0;
    logic              cmd_ready;
    logic              cmd_write = 0;
    logic [ADDR_W-1:0] cmd_addr = 0;
    logic [31:0]       cmd_wdata = 0;
    logic [3:0]        cmd_strb = 0;
    logic              rsp_valid;
    logic              rsp_ready = 0;
    logic [31:0]       rsp_rdata;
    logic              rsp_error;
    logic              rsp_timeout;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [31:0]       PWDATA;
    logic [3:0]        PSTRB;
    logic [31:0]       PRDATA = 0;
    logic              PREADY = 0;
    logic              PSLVERR = 0;

    int checks = 0;
    int errors = 0;

    apb_master #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // One full transfer; slave inserts `waits` wait states then PREADY.
    task automatic xfer(input bit w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] s,
                        input int waits, input bit err,
                        input logic [31:0] rd, input int hold);
        int n;
        bit exp_to;
        int exp_n;
        logic [31:0] exp_rd;
        logic [3:0] exp_strb;
        logic [33:0] snap;
        exp_to   = (TIMEOUT != 0) && (waits >= TIMEOUT);
        exp_n    = exp_to ? TIMEOUT : waits + 1;
        exp_rd   = (exp_to || w) ? 32'h0 : rd;
        exp_strb = w ? s : 4'h0;
        checks++;
        if (cmd_ready !== 1'b1 || PSEL !== 1'b0) begin
            errors++;
            $display("FAIL idle_before rdy=%b psel=%b exp 1/0", cmd_ready, PSEL);
        end
        cmd_valid = 1; cmd_write = w; cmd_addr = a;
        cmd_wdata = wd; cmd_strb = s; PREADY = 0; rsp_ready = 0;
        tick();
        cmd_valid = 0; cmd_write = $urandom; cmd_addr = $urandom;
        cmd_wdata = $urandom; cmd_strb = 4'($urandom);
        checks++;
        if (PSEL !== 1'b1 || PENABLE !== 1'b0 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL setup psel=%b pen=%b rdy=%b exp 1/0/0",
                     PSEL, PENABLE, cmd_ready);
        end
        checks++;
        if (PADDR !== a || PWRITE !== w || PWDATA !== wd || PSTRB !== exp_strb) begin
            errors++;
            $display("FAIL setup_bus addr=%h wr=%b wd=%h strb=%h exp %h/%b/%h/%h",
                     PADDR, PWRITE, PWDATA, PSTRB, a, w, wd, exp_strb);
        end
        tick();
        n = 0;
        while (PSEL === 1'b1 && n < 60) begin
            checks++;
            if (PENABLE !== 1'b1 || PADDR !== a || PWDATA !== wd ||
                PWRITE !== w || PSTRB !== exp_strb || rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL access_%0d pen=%b addr=%h wd=%h strb=%h rv=%b exp 1/%h/%h/%h/0",
                         n, PENABLE, PADDR, PWDATA, PSTRB, rsp_valid, a, wd, exp_strb);
            end
            PREADY  = (n == waits);
            PRDATA  = PREADY ? rd : $urandom;
            PSLVERR = PREADY ? err : 1'($urandom);
            tick();
            n++;
        end
        PREADY = 0; PSLVERR = 0;
        checks++;
        if (n !== exp_n || PSEL !== 1'b0 || PENABLE !== 1'b0) begin
            errors++;
            $display("FAIL access_len got %0d psel=%b pen=%b exp %0d/0/0",
                     n, PSEL, PENABLE, exp_n);
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rd ||
            rsp_error !== (exp_to | err) || rsp_timeout !== exp_to) begin
            errors++;
            $display("FAIL rsp v=%b rd=%h err=%b to=%b exp 1/%h/%b/%b",
                     rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
                     exp_rd, exp_to | err, exp_to);
        end
        snap = {rsp_rdata, rsp_error, rsp_timeout};
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1; cmd_addr = $urandom;
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || {rsp_rdata, rsp_error, rsp_timeout} !== snap ||
                cmd_ready !== 1'b0 || PSEL !== 1'b0 || PADDR !== a) begin
                errors++;
                $display("FAIL hold_%0d rv=%b rsp=%h rdy=%b psel=%b addr=%h exp 1/%h/0/0/%h",
                         i, rsp_valid, {rsp_rdata, rsp_error, rsp_timeout},
                         cmd_ready, PSEL, PADDR, snap, a);
            end
        end
        cmd_valid = 0; rsp_ready = 1;
        tick();
        rsp_ready = 0;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || PSEL !== 1'b0 ||
            PADDR !== a || PWDATA !== wd) begin
            errors++;
            $display("FAIL handshake rv=%b rdy=%b psel=%b addr=%h wd=%h exp 0/1/0/%h/%h",
                     rsp_valid, cmd_ready, PSEL, PADDR, PWDATA, a, wd);
        end
    endtask

    task automatic test_reset();
        PRESET = 1;
        tick(); tick();
        checks++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_valid,
             rsp_rdata, rsp_error, rsp_timeout} !== '0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset psel=%b pen=%b addr=%h wd=%h rv=%b rd=%h rdy=%b exp zeros, rdy=1",
                     PSEL, PENABLE, PADDR, PWDATA, rsp_valid, rsp_rdata, cmd_ready);
        end
        PRESET = 0;
        tick();
    endtask

    task automatic test_zero_wait_write();
        xfer(1, 32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 32'h0, 0);
    endtask

    task automatic test_wait_read();
        xfer(0, 32'h01, 32'hCAFEF00D, 4'hA, 3, 0, 32'h12345678, 0);
    endtask

    task automatic test_slave_error();
        xfer(0, 32'h100, 32'h0, 4'h0, 0, 1, 32'h55AA55AA, 0);
    endtask

    task automatic test_timeout();
        xfer(0, 32'h200, 32'h0, 4'h0, 1000, 0, 32'h0BADBEEF, 0);
        xfer(0, 32'h204, 32'h0, 4'h0, TIMEOUT - 1, 0, 32'h600DF00D, 0);
        xfer(1, 32'h208, 32'h11112222, 4'h3, 1000, 0, 32'h0, 1);
    endtask

    task automatic test_backpressure();
        xfer(0, 32'h300, 32'h0, 4'h0, 2, 1, 32'hA5A5A5A5, 5);
        xfer(1, 32'h304, 32'h77778888, 4'h9, 0, 0, 32'h0, 0);
    endtask

    task automatic test_reset_mid();
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h400; PREADY = 0;
        tick();
        cmd_valid = 0;
        tick(); tick(); tick();
        PRESET = 1; PREADY = 1; PRDATA = 32'hFFFF0000;
        tick();
        PREADY = 0;
        checks++;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid psel=%b pen=%b rv=%b exp 0/0/0",
                     PSEL, PENABLE, rsp_valid);
        end
        PRESET = 0;
        tick(); tick();
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || PSEL !== 1'b0) begin
            errors++;
            $display("FAIL reset_release rdy=%b rv=%b psel=%b exp 1/0/0",
                     cmd_ready, rsp_valid, PSEL);
        end
        xfer(0, 32'h404, 32'h0, 4'h0, 1, 0, 32'h13572468, 0);
    endtask

    task automatic test_random();
        int waits;
        for (int i = 0; i < 24; i++) begin
            waits = ($urandom_range(0, 5) == 0) ? int'($urandom_range(14, 30))
                                                : int'($urandom_range(0, 4));
            xfer(1'($urandom), $urandom, $urandom, 4'($urandom), waits,
                 1'($urandom), $urandom, int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_zero_wait_write();
        test_wait_read();
        test_slave_error();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
